// File: rtl/stream_mux_n_pkg.sv
// Shared constants and helpers for the N-input stream multiplexer.
package stream_mux_n_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Width of an index over n items, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between the producers, the multiplexer and its consumer.
interface stream_mux_n_if
  import stream_mux_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4
);
  localparam int SEL_W = clog2(N_IN);

  logic [N_IN*WIDTH-1:0] in_data;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [SEL_W-1:0]      sel;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_W-1:0]      out_src;

  modport master (
    output in_data, in_valid, sel, flush, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, sel, flush, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, wrapping.
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  always_comb begin : search
    logic             found;
    logic [SEL_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    grant = ptr;
    for (int k = 1; k <= N_IN; k++) begin
      idx = SEL_W'((int'(ptr) + k) % N_IN);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign grant_valid = |req;

endmodule

// File: rtl/stream_mux_n.sv
// N-input valid/ready multiplexer with one registered output stage,
// selecting by explicit sel (MODE_SEL) or round-robin (MODE_RR).
module stream_mux_n
  import stream_mux_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int MODE  = MODE_SEL
) (
  input  logic           clk,
  input  logic           reset,
  stream_mux_n_if.slave  bus
);

  localparam int SEL_W = clog2(N_IN);

  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  logic [N_IN-1:0]  rdy;
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] out_data_p0;
  logic [SEL_W-1:0] out_src_p0;
  logic             vld_p0;

  assign load_en = (!vld_p0 || bus.out_ready) && !bus.flush;
  assign xfer    = load_en && grant_valid;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] rr_ptr;

      rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
      ) u_arb (
        .req         (bus.in_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
      );

      // Pointer starts at the last input so the first search begins at input 0.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rr_ptr <= SEL_W'(N_IN - 1);
        end else if (xfer) begin
          rr_ptr <= grant;
        end
      end
    end else begin : g_sel
      // Zero-padded request vector lets an out-of-range sel read a safe 0.
      logic [2**SEL_W-1:0] req_pad;

      always_comb begin
        req_pad            = '0;
        req_pad[N_IN-1:0]  = bus.in_valid;
      end

      assign grant       = bus.sel;
      assign grant_valid = (int'(bus.sel) < N_IN) && req_pad[bus.sel];
    end
  endgenerate

  always_comb begin
    rdy      = '0;
    sel_data = '0;
    for (int i = 0; i < N_IN; i++) begin
      rdy[i] = xfer && (int'(grant) == i);
      if (int'(grant) == i) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.in_ready = rdy;

  // Output stage p0: flush beats both refill and drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      out_data_p0 <= '0;
      out_src_p0  <= '0;
    end else if (bus.flush) begin
      vld_p0      <= 1'b0;
    end else if (xfer) begin
      vld_p0      <= 1'b1;
      out_data_p0 <= sel_data;
      out_src_p0  <= grant;
    end else if (bus.out_ready) begin
      vld_p0      <= 1'b0;
    end
  end

  assign bus.out_data  = out_data_p0;
  assign bus.out_valid = vld_p0;
  assign bus.out_src   = out_src_p0;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: explicit-select and round-robin instances at N_IN=4
// against a transaction-level model, plus an N_IN=3 instance for range edges.
module tb_stream_mux_n;
  import stream_mux_n_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic [1:0]   sel = '0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic        m_valid [2];
  logic [31:0] m_data  [2];
  int          m_src   [2];
  int          m_ptr;

  always #5 clk = ~clk;

  stream_mux_n_if #(.WIDTH(32), .N_IN(4)) if0 ();
  stream_mux_n_if #(.WIDTH(32), .N_IN(4)) if1 ();
  stream_mux_n_if #(.WIDTH(32), .N_IN(3)) if2 ();

  assign if0.in_data   = in_data;
  assign if0.in_valid  = in_valid;
  assign if0.sel       = sel;
  assign if0.flush     = flush;
  assign if0.out_ready = out_ready;
  assign if1.in_data   = in_data;
  assign if1.in_valid  = in_valid;
  assign if1.sel       = sel;
  assign if1.flush     = flush;
  assign if1.out_ready = out_ready;

  stream_mux_n #(.WIDTH(32), .N_IN(4), .MODE(MODE_SEL)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  stream_mux_n #(.WIDTH(32), .N_IN(4), .MODE(MODE_RR))  dut1 (.clk(clk), .reset(reset), .bus(if1));
  stream_mux_n #(.WIDTH(32), .N_IN(3), .MODE(MODE_SEL)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which input the spec's rules pick this cycle, or -1 for none.
  function automatic int exp_grant(input int mode);
    if (mode == 0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= 4; k++) begin
      if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = '0;
      m_src[d]   = 0;
    end
    m_ptr = 3;
  endtask

  task automatic chk_out();
    chk("vld0", 64'(if0.out_valid), 64'(m_valid[0]));
    chk("data0", 64'(if0.out_data), 64'(m_data[0]));
    chk("src0", 64'(if0.out_src), 64'(m_src[0]));
    chk("vld1", 64'(if1.out_valid), 64'(m_valid[1]));
    chk("data1", 64'(if1.out_data), 64'(m_data[1]));
    chk("src1", 64'(if1.out_src), 64'(m_src[1]));
  endtask

  // Check ready against the model, clock once, advance model, check outputs.
  task automatic cycle();
    int         g [2];
    bit         xf [2];
    logic [3:0] er;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]  = exp_grant(d);
      xf[d] = (g[d] >= 0) && (!m_valid[d] || out_ready) && !flush;
      er = '0;
      if (xf[d]) er[g[d]] = 1'b1;
      chk(d == 0 ? "rdy0" : "rdy1", 64'(d == 0 ? if0.in_ready : if1.in_ready), 64'(er));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (flush) m_valid[d] = 1'b0;
      else if (xf[d]) begin
        m_valid[d] = 1'b1;
        m_data[d]  = in_data[g[d]*32 +: 32];
        m_src[d]   = g[d];
        if (d == 1) m_ptr = g[d];
      end else if (out_ready) m_valid[d] = 1'b0;
    end
    #1;
    chk_out();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [31:0] held;
    int          exp_seq [3];
    if2.in_data   = '0;
    if2.in_valid  = '0;
    if2.sel       = '0;
    if2.flush     = 1'b0;
    if2.out_ready = 1'b0;
    model_reset();

    #2;
    apply_reset();
    chk_out();
    chk("rst_vld2", 64'(if2.out_valid), 64'd0);
    chk("rst_data2", 64'(if2.out_data), 64'd0);
    chk("rst_src2", 64'(if2.out_src), 64'd0);

    // N_IN=3 instance: in-range select, then out-of-range sel=3.
    if2.sel = 2'd2;
    if2.in_valid = 3'b100;
    if2.in_data[95:64] = 32'hCAFEF00D;
    if2.out_ready = 1'b1;
    #1;
    chk("n3_rdy", 64'(if2.in_ready), 64'b100);
    cycle();
    chk("n3_vld", 64'(if2.out_valid), 64'd1);
    chk("n3_data", 64'(if2.out_data), 64'hCAFEF00D);
    chk("n3_src", 64'(if2.out_src), 64'd2);
    if2.sel = 2'd3;
    if2.in_valid = 3'b111;
    #1;
    chk("n3_oor_rdy", 64'(if2.in_ready), 64'b000);
    cycle();
    chk("n3_oor_vld", 64'(if2.out_valid), 64'd0);
    chk("n3_hold_data", 64'(if2.out_data), 64'hCAFEF00D);

    // Explicit select of input 2.
    sel = 2'd2;
    in_valid = 4'b0100;
    in_data[95:64] = 32'hDEADBEEF;
    out_ready = 1'b1;
    #1;
    chk("t1_rdy", 64'(if0.in_ready), 64'b0100);
    cycle();
    chk("t1_data", 64'(if0.out_data), 64'hDEADBEEF);
    chk("t1_src", 64'(if0.out_src), 64'd2);

    // Back-pressure for three cycles while inputs churn.
    out_ready = 1'b0;
    held = if0.out_data;
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'($urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      sel = 2'($urandom);
      cycle();
      chk("bp_hold", 64'(if0.out_data), 64'(held));
    end
    out_ready = 1'b1;
    sel = 2'd0;
    in_valid = 4'b0001;
    in_data[31:0] = 32'h12345678;
    cycle();
    chk("bp_release", 64'(if0.out_data), 64'h12345678);

    // Round-robin over all-valid inputs from reset.
    apply_reset();
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      chk("rr_seq", 64'(if1.out_src), 64'(k % 4));
    end

    // Sparse round-robin: last grant 1, then 1010 alternates 3,1,3.
    in_valid = 4'b0010;
    cycle();
    chk("rr_last1", 64'(if1.out_src), 64'd1);
    in_valid = 4'b1010;
    exp_seq = '{3, 1, 3};
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("rr_sparse", 64'(if1.out_src), 64'(exp_seq[k]));
    end

    // Flush blocks the transfer and leaves the pointer where it was.
    in_valid = 4'b0001;
    flush = 1'b1;
    cycle();
    chk("flush_vld", 64'(if1.out_valid), 64'd0);
    flush = 1'b0;
    in_valid = 4'b1111;
    cycle();
    chk("flush_ptr", 64'(if1.out_src), 64'd0);

    // Asynchronous reset in the middle of a cycle while streaming.
    cycle();
    reset = 1'b1;
    #1;
    chk("arst_vld0", 64'(if0.out_valid), 64'd0);
    chk("arst_data0", 64'(if0.out_data), 64'd0);
    chk("arst_vld1", 64'(if1.out_valid), 64'd0);
    chk("arst_data1", 64'(if1.out_data), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    in_valid = 4'b1111;
    cycle();
    chk("arst_first", 64'(if1.out_src), 64'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      in_valid  = 4'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
Parametrised N-input, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input and on the output. It generalises the 32-bit 2:1 datapath select in two ways. First, it arbitrates among requesting sources, either by explicit select or by round-robin. Second, it holds its result under back-pressure. Used where several producers share one pipeline consumer, e.g. writeback-source or memory-request selection in the multicycle/pipelined MIPS datapath.

Parameters:
WIDTH, 32, data width per input and output
N_IN, 4, number of inputs (>=2)
MODE, 0, 0 = explicit select via sel port; 1 = round-robin among valid inputs (sel ignored)
SEL_W, clog2(N_IN), local constant; width of sel, out_src and the round-robin pointer (not overridable)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  N_IN*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N_IN  per-input request
in_ready  output  N_IN  per-input accept (combinational)
sel  input  SEL_W  explicit source select (MODE 0 only)
flush  input  1  synchronous drop of the output register contents
out_data  output  WIDTH  registered selected data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer accept
out_src  output  SEL_W  index of the input that produced out_data

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_src=0, rr_ptr=N_IN-1, so the first round-robin search starts at input 0.
- load_en = (!out_valid || out_ready) && !flush.
- Grant, MODE 0: grant_valid = (sel < N_IN) && in_valid[sel]; grant = sel. An out-of-range sel yields no grant.
- Grant, MODE 1: search from rr_ptr+1 upward, wrapping modulo N_IN; grant the first i with in_valid[i]=1. grant_valid = |in_valid.
- in_ready[i] = load_en && grant_valid && (grant == i). At most one bit is set. in_ready never depends on in_valid[i] itself, except through the grant.
- Transfer on input i: in_valid[i] && in_ready[i]. On the next edge: out_data <= in_data[i], out_src <= i, out_valid <= 1. In MODE 1 only, rr_ptr <= i.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Full throughput: with out_ready held at 1, one word per cycle.
- Output drain without refill: out_valid && out_ready && !grant_valid -> out_valid <= 0. out_data and out_src keep their last values.
- Stall: out_valid && !out_ready -> out_data, out_src and out_valid hold; all in_ready=0.
- Flush: out_valid <= 0 on the next edge; in_ready all 0 that cycle; rr_ptr unchanged. Flush wins over a simultaneous out_ready or input transfer.
- Reset mid-transfer: the word in flight is discarded and rr_ptr returns to N_IN-1.
- No combinational path from in_data to out_data. The path out_ready -> in_ready is combinational by design (no skid buffer).

Decomposition:
- Shared package: MODE_SEL=0 and MODE_RR=1 constants, plus a clog2 function for SEL_W.
- One sub-module, rr_arbiter (N_IN, SEL_W): inputs req and ptr; outputs grant and grant_valid. Purely combinational; instantiated only when MODE=1.
- The output register stage stays in stream_mux_n.

Test Plan:
1. MODE 0, N_IN=4, sel=2, in_valid=0100, in_data[2]=0xDEADBEEF, out_ready=1 -> in_ready=0100 that cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_src=2. Then set N_IN=3, sel=3 -> in_ready=000 and out_valid falls to 0.
2. Back-pressure: out_valid=1, out_ready=0 for 3 cycles while inputs change -> in_ready=0 and out_data constant. Raise out_ready -> the new word appears 1 cycle later.
3. MODE 1, in_valid=1111 held, out_ready=1, after reset -> out_src sequence 0,1,2,3,0 on consecutive cycles.
4. MODE 1, last grant=1, in_valid=1010 -> next grant 3, then 1, then 3. Inputs 0 and 2 never receive in_ready.
5. Flush with out_valid=1, out_ready=1, in_valid=0001 -> in_ready=0 that cycle, out_valid=0 next cycle, rr_ptr unchanged.
6. Assert reset asynchronously mid-cycle during streaming -> out_valid=0, out_data=0 immediately. After deassertion in MODE 1 with in_valid=1111, first out_src=0.
